picorv32_issue_stage: RTL

Upstream feeder for `picorv32_pipeline`. It accepts tagged ALU requests (instruction word, operands `a` and `b`, tag) over a valid/ready handshake and buffers them in an input queue. It issues one request per cycle into the pipeline with the skew the pipeline needs: the instruction word in the issue cycle, the operands one cycle later. It collects `pipe_result` two cycles after issue and returns it with its tag through a return queue under valid/ready, using credit-based issue so that no result is ever dropped.

---
 rtl/picorv32_pkg.sv | 19 +
 rtl/picorv32_sync_fifo.sv | 39 +++
 rtl/picorv32_issue_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/picorv32_pkg.sv
// Shared types and constants for the picorv32 issue stage and its queues.
package picorv32_pkg;

  localparam int PIPE_LAT   = 2;
  localparam int TAG_W_DFLT = 4;

  typedef struct packed {
    logic [31:0]           instr;
    logic [31:0]           a;
    logic [31:0]           b;
    logic [TAG_W_DFLT-1:0] tag;
  } issue_entry_t;

  typedef struct packed {
    logic [31:0]           result;
    logic [TAG_W_DFLT-1:0] tag;
  } ret_entry_t;

endpackage

// File: rtl/picorv32_sync_fifo.sv
// Synchronous FIFO with occupancy count; callers never push when full or pop when empty.
module picorv32_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage carries no reset; stale contents are hidden by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/picorv32_issue_stage.sv
// Credit-based feeder for picorv32_pipeline: queues requests, skews instr/operands, returns tagged results.
// Optional PICORV32_ISSUE_PERF_EN adds perf_issued / perf_stall counters.
module picorv32_issue_stage
  import picorv32_pkg::*;
#(
  parameter int Q_DEPTH   = 4,
  parameter int RET_DEPTH = 4,
  parameter int TAG_W     = TAG_W_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      pipe_instr,
  output logic [31:0]      pipe_a,
  output logic [31:0]      pipe_b,
  input  logic [31:0]      pipe_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
`ifdef PICORV32_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_issued,
  output logic [31:0]      perf_stall
`endif
);

  localparam int QW = $clog2(Q_DEPTH);
  localparam int RW = $clog2(RET_DEPTH);

  issue_entry_t     in_entry;
  issue_entry_t     q_head;
  logic [QW:0]      q_count;
  logic             q_push;
  logic             q_empty;

  ret_entry_t       ret_in;
  ret_entry_t       ret_head;
  logic [RW:0]      ret_count;
  logic             ret_pop;
  logic             ret_full;

  logic             vld_p1;
  logic             vld_p2;
  logic [TAG_W_DFLT-1:0] tag_p1;
  logic [TAG_W_DFLT-1:0] tag_p2;
  logic [31:0]      a_p1;
  logic [31:0]      b_p1;

  logic [RW+1:0]    pending;
  logic             credit_ok;
  logic             issue;

  assign in_ready = (q_count < (QW+1)'(Q_DEPTH));
  assign q_push   = in_valid && in_ready;
  assign q_empty  = (q_count == '0);
  assign in_entry = '{instr: in_instr, a: in_a, b: in_b, tag: TAG_W_DFLT'(in_tag)};

  picorv32_sync_fifo #(
    .WIDTH ($bits(issue_entry_t)),
    .DEPTH (Q_DEPTH)
  ) u_in_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data (in_entry),
    .pop       (issue),
    .pop_data  (q_head),
    .count     (q_count)
  );

  // Credit counts held results plus both in-flight slots; a same-cycle return pop is ignored.
  assign pending   = (RW+2)'(ret_count) + (RW+2)'(vld_p1) + (RW+2)'(vld_p2);
  assign credit_ok = (pending < (RW+2)'(RET_DEPTH));
  assign issue     = !q_empty && credit_ok;

  // Stage p0: issue cycle, instruction word straight from the queue head.
  assign pipe_instr = issue ? q_head.instr : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= issue;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      tag_p1 <= q_head.tag;
      a_p1   <= q_head.a;
      b_p1   <= q_head.b;
    end
    tag_p2 <= tag_p1;
  end

  // Stage p1: operand cycle.
  assign pipe_a = vld_p1 ? a_p1 : '0;
  assign pipe_b = vld_p1 ? b_p1 : '0;

  // Stage p2: result capture into the return queue.
  assign ret_in  = '{result: pipe_result, tag: tag_p2};
  assign ret_pop = out_valid && out_ready;

  picorv32_sync_fifo #(
    .WIDTH ($bits(ret_entry_t)),
    .DEPTH (RET_DEPTH)
  ) u_ret_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_p2),
    .push_data (ret_in),
    .pop       (ret_pop),
    .pop_data  (ret_head),
    .count     (ret_count)
  );

  assign ret_full   = (ret_count == (RW+1)'(RET_DEPTH));
  assign out_valid  = (ret_count != '0);
  assign out_result = out_valid ? ret_head.result : '0;
  assign out_tag    = out_valid ? TAG_W'(ret_head.tag) : '0;

  a_no_ret_overflow: assert property (@(posedge clk) disable iff (!rst_n) vld_p2 |-> !ret_full);

`ifdef PICORV32_ISSUE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (issue)                 perf_issued <= perf_issued + 32'd1;
      if (!q_empty && !credit_ok) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
